// File: rtl/lut_pkg.sv
// Shared types and default constants for the lookup-table bank.
package lut_pkg;

  typedef enum logic [1:0] {IDLE, FILL, READY} lut_state_e;

  localparam int NUM_CONST = 30;

  // Tap masks first, then immediate constants.
  localparam logic [7:0] DEFAULT_TABLE [NUM_CONST] = '{
    8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B,
    8'd61, 8'd62, 8'd63, 8'd64, 8'd128, 8'd130, 8'd32, 8'd49, 8'd140,
    8'd141, 8'd9, 8'd142, 8'd143, 8'd144, 8'd127, 8'd15, 8'd145, 8'd128,
    8'd146, 8'd147, 8'd65
  };

endpackage

// File: rtl/lut_default_rom.sv
// Combinational default-constant ROM feeding the fill sequencer; zero past the table end.
module lut_default_rom
  import lut_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_idx,
  output logic [W-1:0]  o_data
);

  logic [7:0] w_raw;

  // Compare-and-select avoids indexing the table past its end.
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_CONST; i++)
      if (int'(i_idx) == i) w_raw = DEFAULT_TABLE[i];
  end

  generate
    if (W >= 8) begin : g_wide
      assign o_data = W'(w_raw);
    end else begin : g_narrow
      assign o_data = w_raw[W-1:0];
    end
  endgenerate

endmodule

// File: rtl/lut_bank.sv
// Multi-port lookup table: self-fills from defaults on init, then serves registered reads
// and runtime single-entry writes.
module lut_bank
  import lut_pkg::*;
#(
  parameter  int W        = 8,
  parameter  int DEPTH    = 32,
  parameter  int RD_PORTS = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             init,
  output logic                             busy,
  output logic                             ready,
  output logic                             done,
  input  logic                             wrEn,
  input  logic [AW-1:0]                    wrAddr,
  input  logic [W-1:0]                     wrData,
  input  logic [RD_PORTS-1:0]              rdEn,
  input  logic [RD_PORTS-1:0][AW-1:0]      rdAddr,
  output logic [RD_PORTS-1:0][W-1:0]       rdData,
  output logic [RD_PORTS-1:0]              rdValid,
  output logic                             addrErr
);

  lut_state_e                  r_state, w_next;
  logic [AW-1:0]               r_fillPtr;
  logic [W-1:0]                r_mem [DEPTH];
  logic [RD_PORTS-1:0][W-1:0]  r_rdData;
  logic [RD_PORTS-1:0]         r_rdValid;
  logic                        r_addrErr;

  logic                        w_lastFill;
  logic [W-1:0]                w_romData;
  logic                        w_wrOk;
  logic                        w_userWe;
  logic [RD_PORTS-1:0]         w_rdOk;
  logic [RD_PORTS-1:0]         w_rdHit;
  logic                        w_errHit;

  assign w_lastFill = (r_fillPtr == AW'(DEPTH - 1));

  lut_default_rom #(.W(W), .AW(AW)) u_rom (
    .i_idx  (r_fillPtr),
    .o_data (w_romData)
  );

  // State register and fill pointer
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_fillPtr <= '0;
    end else begin
      r_state <= w_next;
      if (init || r_state != FILL || w_lastFill) r_fillPtr <= '0;
      else                                       r_fillPtr <= r_fillPtr + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (init) w_next = FILL;
      FILL:    if (init) w_next = FILL;
               else if (w_lastFill) w_next = READY;
      READY:   if (init) w_next = FILL;
      default: w_next = IDLE;
    endcase
  end

  // A restart on the final fill cycle wins, so no done pulse then.
  always_comb begin
    busy  = (r_state == FILL);
    ready = (r_state == READY);
    done  = (r_state == FILL) && w_lastFill && !init;
  end

  assign w_wrOk   = (32'(wrAddr) < DEPTH);
  assign w_userWe = ready && wrEn && !init && w_wrOk;

  always_comb begin
    w_rdOk  = '0;
    w_rdHit = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      w_rdOk[p]  = (32'(rdAddr[p]) < DEPTH);
      w_rdHit[p] = ready && rdEn[p];
    end
  end

  assign w_errHit = (ready && wrEn && !init && !w_wrOk) || |(w_rdHit & ~w_rdOk);

  // Storage has no reset; contents are only trusted after a completed fill.
  always_ff @(posedge clk) begin
    if (r_state == FILL) r_mem[r_fillPtr] <= w_romData;
    else if (w_userWe)   r_mem[wrAddr]    <= wrData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rdData  <= '0;
      r_rdValid <= '0;
      r_addrErr <= 1'b0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        r_rdValid[p] <= w_rdHit[p];
        if (w_rdHit[p]) r_rdData[p] <= w_rdOk[p] ? r_mem[rdAddr[p]] : '0;
      end
      if (init)          r_addrErr <= 1'b0;
      else if (w_errHit) r_addrErr <= 1'b1;
    end
  end

  assign rdData  = r_rdData;
  assign rdValid = r_rdValid;
  assign addrErr = r_addrErr;

endmodule

// File: tb/tb_lut_bank.sv
// Scoreboard bench for lut_bank: a 32-entry and a 40-entry build on one clock.
module tb_lut_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstN, init, wrEn, busy, ready, done, addrErr;
  logic [4:0]      wrAddr;
  logic [7:0]      wrData;
  logic [1:0]      rdEn, rdValid;
  logic [1:0][4:0] rdAddr;
  logic [1:0][7:0] rdData;

  logic            init_b, wrEn_b, busy_b, ready_b, done_b, addrErr_b;
  logic [5:0]      wrAddr_b;
  logic [7:0]      wrData_b;
  logic [1:0]      rdEn_b, rdValid_b;
  logic [1:0][5:0] rdAddr_b;
  logic [1:0][7:0] rdData_b;

  lut_bank #(.W(8), .DEPTH(32), .RD_PORTS(2)) dut (
    .clk(clk), .rstN(rstN), .init(init), .busy(busy), .ready(ready), .done(done),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(rdData), .rdValid(rdValid), .addrErr(addrErr)
  );

  lut_bank #(.W(8), .DEPTH(40), .RD_PORTS(2)) dut_b (
    .clk(clk), .rstN(rstN), .init(init_b), .busy(busy_b), .ready(ready_b), .done(done_b),
    .wrEn(wrEn_b), .wrAddr(wrAddr_b), .wrData(wrData_b), .rdEn(rdEn_b), .rdAddr(rdAddr_b),
    .rdData(rdData_b), .rdValid(rdValid_b), .addrErr(addrErr_b)
  );

  logic [7:0] tbl [30] = '{
    8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B,
    8'd61, 8'd62, 8'd63, 8'd64, 8'd128, 8'd130, 8'd32, 8'd49, 8'd140,
    8'd141, 8'd9, 8'd142, 8'd143, 8'd144, 8'd127, 8'd15, 8'd145, 8'd128,
    8'd146, 8'd147, 8'd65
  };
  logic [7:0] mdl [32];
  logic [7:0] mdl_b [40];
  bit exp_rdy = 0, exp_rdy_b = 0, m_err_b = 0;

  typedef struct { int due; logic [7:0] d; } exp_t;
  exp_t q0[$], q1[$], qb[$];

  int n_tot = 0, n_bad = 0, cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each expected read is due on the negedge after the edge that launched it.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].due == cyc_n) begin
      e = q0.pop_front();
      chk("p0_vld", rdValid[0], 1);
      chk("p0_dat", rdData[0], e.d);
    end else if (rdValid[0]) chk("p0_spur", rdValid[0], 0);
    if (q1.size() > 0 && q1[0].due == cyc_n) begin
      e = q1.pop_front();
      chk("p1_vld", rdValid[1], 1);
      chk("p1_dat", rdData[1], e.d);
    end else if (rdValid[1]) chk("p1_spur", rdValid[1], 0);
    if (qb.size() > 0 && qb[0].due == cyc_n) begin
      e = qb.pop_front();
      chk("b0_vld", rdValid_b[0], 1);
      chk("b0_dat", rdData_b[0], e.d);
    end else if (rdValid_b[0]) chk("b0_spur", rdValid_b[0], 0);
    if (rdValid_b[1]) chk("b1_spur", rdValid_b[1], 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_model();
    for (int i = 0; i < 32; i++) mdl[i] = (i < 30) ? tbl[i] : 8'h00;
    for (int i = 0; i < 40; i++) mdl_b[i] = (i < 30) ? tbl[i] : 8'h00;
  endtask

  task automatic issue(input bit e0, input logic [4:0] a0, input bit e1, input logic [4:0] a1,
                       input bit we, input logic [4:0] wa, input logic [7:0] wd);
    rdEn = {e1, e0}; rdAddr[0] = a0; rdAddr[1] = a1;
    wrEn = we; wrAddr = wa; wrData = wd;
    if (exp_rdy) begin
      if (e0) q0.push_back('{cyc_n + 1, mdl[a0]});
      if (e1) q1.push_back('{cyc_n + 1, mdl[a1]});
      if (we && !init) mdl[wa] = wd;
    end
    cyc();
    rdEn = '0; wrEn = 1'b0;
  endtask

  task automatic issue_b(input bit e0, input logic [5:0] a0,
                         input bit we, input logic [5:0] wa, input logic [7:0] wd);
    rdEn_b = {1'b0, e0}; rdAddr_b[0] = a0; rdAddr_b[1] = '0;
    wrEn_b = we; wrAddr_b = wa; wrData_b = wd;
    if (exp_rdy_b) begin
      if (e0) qb.push_back('{cyc_n + 1, (a0 < 40) ? mdl_b[a0] : 8'h00});
      if (!init_b) begin
        if (we && wa < 40) mdl_b[wa] = wd;
        if ((e0 && a0 >= 40) || (we && wa >= 40)) m_err_b = 1;
      end
    end
    cyc();
    rdEn_b = '0; wrEn_b = 1'b0;
  endtask

  task automatic run_fill(input int depth, input bit sb);
    for (int k = 0; k < depth; k++) begin
      chk("fill_busy", sb ? busy_b : busy, 1);
      chk("fill_done", sb ? done_b : done, (k == depth - 1));
      cyc();
    end
    chk("fill_rdy", sb ? ready_b : ready, 1);
    chk("fill_done_end", sb ? done_b : done, 0);
  endtask

  initial begin
    rstN = 0; init = 0; wrEn = 0; wrAddr = '0; wrData = '0; rdEn = '0; rdAddr = '0;
    init_b = 0; wrEn_b = 0; wrAddr_b = '0; wrData_b = '0; rdEn_b = '0; rdAddr_b = '0;
    repeat (2) cyc();
    chk("rst_busy", busy, 0);   chk("rst_ready", ready, 0); chk("rst_done", done, 0);
    chk("rst_vld", rdValid, 0); chk("rst_dat", rdData, 0);  chk("rst_err", addrErr, 0);
    rstN = 1;
    cyc();

    // T1: fill timing and first reads
    init = 1; cyc(); init = 0;
    run_fill(32, 0);
    fill_model(); exp_rdy = 1;
    issue(1, 5'd0, 0, 5'd0, 0, 5'd0, 8'h00);  chk("t1_a0", rdData[0], 8'h60);
    issue(1, 5'd29, 0, 5'd0, 0, 5'd0, 8'h00); chk("t1_a29", rdData[0], 8'd65);
    issue(1, 5'd30, 0, 5'd0, 0, 5'd0, 8'h00); chk("t1_a30", rdData[0], 8'h00);

    // T2: read-first on same-address write
    issue(1, 5'd5, 0, 5'd0, 1, 5'd5, 8'hAA); chk("t2_old", rdData[0], 8'h69);
    issue(1, 5'd5, 0, 5'd0, 0, 5'd0, 8'h00); chk("t2_new", rdData[0], 8'hAA);

    // T3: shared address on both ports, then one idle port
    issue(1, 5'd3, 1, 5'd3, 0, 5'd0, 8'h00);
    chk("t3_vld2", rdValid, 2'b11); chk("t3_p1", rdData[1], 8'h72);
    issue(1, 5'd8, 0, 5'd0, 0, 5'd0, 8'h00);
    chk("t3_vld1", rdValid, 2'b01); chk("t3_p0", rdData[0], 8'h7B);
    issue(0, 5'd0, 0, 5'd0, 1, 5'd2, 8'hEE);
    issue(1, 5'd2, 0, 5'd0, 0, 5'd0, 8'h00); chk("t3_wr2", rdData[0], 8'hEE);

    // T4: restart fill at fillPtr=10; a write alongside init is dropped
    init = 1; issue(0, 5'd0, 0, 5'd0, 1, 5'd2, 8'h11); init = 0; exp_rdy = 0;
    chk("t4_rdy_drop", ready, 0);
    for (int k = 0; k < 10; k++) begin
      chk("t4_busy", busy, 1); chk("t4_done", done, 0); cyc();
    end
    init = 1; cyc(); init = 0;
    run_fill(32, 0);
    fill_model(); exp_rdy = 1;
    for (int i = 0; i < 10; i++) issue(1, 5'(i), 1, 5'(31 - i), 0, 5'd0, 8'h00);
    issue(1, 5'd2, 0, 5'd0, 0, 5'd0, 8'h00); chk("t4_a2", rdData[0], 8'h78);

    // T5: async reset mid-fill
    init = 1; cyc(); init = 0; exp_rdy = 0;
    repeat (5) cyc();
    #2 rstN = 0;
    #1;
    chk("t5_busy", busy, 0); chk("t5_ready", ready, 0);
    chk("t5_done", done, 0); chk("t5_vld", rdValid, 0);
    repeat (2) cyc();
    rstN = 1;
    issue(1, 5'd0, 1, 5'd1, 0, 5'd0, 8'h00);
    chk("t5_ign_vld", rdValid, 0); chk("t5_idle_busy", busy, 0);
    init = 1; cyc(); init = 0;
    run_fill(32, 0);
    fill_model(); exp_rdy = 1;
    issue(1, 5'd1, 0, 5'd0, 0, 5'd0, 8'h00); chk("t5_a1", rdData[0], 8'h48);
    chk("t5_err", addrErr, 0);

    // T6: non-power-of-two depth, out-of-range handling
    init_b = 1; cyc(); init_b = 0;
    run_fill(40, 1);
    exp_rdy_b = 1;
    issue_b(1, 6'd35, 1, 6'd45, 8'h5A);
    chk("t6_a35", rdData_b[0], 8'h00); chk("t6_err", addrErr_b, m_err_b);
    issue_b(1, 6'd13, 0, 6'd0, 8'h00); chk("t6_a13", rdData_b[0], 8'h80);
    issue_b(1, 6'd5, 0, 6'd0, 8'h00);  chk("t6_a5", rdData_b[0], 8'h69);
    repeat (3) cyc();
    chk("t6_sticky", addrErr_b, 1);
    init_b = 1; cyc(); init_b = 0; exp_rdy_b = 0; m_err_b = 0;
    chk("t6_err_clr", addrErr_b, 0);
    run_fill(40, 1);
    exp_rdy_b = 1;
    issue_b(1, 6'd50, 0, 6'd0, 8'h00);
    chk("t6_oor_vld", rdValid_b[0], 1); chk("t6_oor_dat", rdData_b[0], 8'h00);
    chk("t6_oor_err", addrErr_b, m_err_b);
    issue_b(1, 6'd39, 0, 6'd0, 8'h00); chk("t6_a39", rdData_b[0], 8'h00);

    repeat (2) cyc();
    chk("q_empty", q0.size() + q1.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
